// File: rtl/switch_led_pkg.sv
// Shared mode encoding and LED drive rule for switch_led_ctrl.
// BLINK support in the top level is gated by the SWITCH_LED_BLINK_EN macro.
package switch_led_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_FOLLOW = 2'b00,
        MODE_TOGGLE = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_OFF    = 2'b11
    } mode_e;

    // Without blink support, BLINK falls back to FOLLOW.
    function automatic logic led_drive(
        input mode_e m,
        input logic  db,
        input logic  tog,
        input logic  phase,
        input logic  blink_en
    );
        logic r;
        r = 1'b0;
        case (m)
            MODE_FOLLOW: r = db;
            MODE_TOGGLE: r = tog;
            MODE_BLINK:  r = blink_en ? (db & phase) : db;
            MODE_OFF:    r = 1'b0;
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/switch_led_ctrl_debounce.sv
// One switch channel: two-flop synchroniser, persistence debounce and
// a registered pulse on each debounced rising edge.
module switch_debounce
    import switch_led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic switch,
    output logic db,
    output logic rise,
    output logic press_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          sync1;
    logic          sw_s;
    logic          db_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1       <= 1'b0;
            sw_s        <= 1'b0;
            db          <= 1'b0;
            db_d        <= 1'b0;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            sync1       <= switch;
            sw_s        <= sync1;
            db_d        <= db;
            press_pulse <= rise;
            // Any sample matching db restarts the persistence window.
            if (sw_s == db) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                db  <= sw_s;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = db & ~db_d;

endmodule

// File: rtl/switch_led_ctrl.sv
// Multi-channel switch-to-LED controller (FOLLOW/TOGGLE/BLINK/OFF per channel).
// Define SWITCH_LED_BLINK_EN to build the shared blink prescaler and BLINK mode.
module switch_led_ctrl
    import switch_led_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int BLINK_DIV       = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        switch,
    input  logic [MODE_W*NUM_CH-1:0] mode,
    output logic [NUM_CH-1:0]        led,
    output logic [NUM_CH-1:0]        press_pulse
);

    if (NUM_CH < 1) begin : g_bad_num_ch
        $error("NUM_CH must be at least 1");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (BLINK_DIV < 1) begin : g_bad_blink_div
        $error("BLINK_DIV must be at least 1");
    end

    logic [NUM_CH-1:0] db;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] tog;
    logic [NUM_CH-1:0] tog_next;
    logic [NUM_CH-1:0] led_next;
    logic              blink_phase;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        switch_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk        (clk),
            .rst_n      (rst_n),
            .switch     (switch[i]),
            .db         (db[i]),
            .rise       (rise[i]),
            .press_pulse(press_pulse[i])
        );
    end

`ifdef SWITCH_LED_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
    localparam int PW       = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [PW-1:0] pre_cnt;

    // One shared prescaler keeps every blinking channel in phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt     <= '0;
            blink_phase <= 1'b0;
        end else if (pre_cnt == PW'(BLINK_DIV - 1)) begin
            pre_cnt     <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end
`else
    localparam bit BLINK_EN = 1'b0;

    assign blink_phase = 1'b0;
`endif

    // The mode sampled on the press edge decides whether the toggle bit flips.
    always_comb begin
        tog_next = tog;
        led_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            tog_next[i] = tog[i] ^ (rise[i] &
                          (mode_e'(mode[MODE_W*i +: MODE_W]) == MODE_TOGGLE));
            led_next[i] = led_drive(mode_e'(mode[MODE_W*i +: MODE_W]),
                                    db[i], tog_next[i], blink_phase, BLINK_EN);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tog <= '0;
            led <= '0;
        end else begin
            tog <= tog_next;
            led <= led_next;
        end
    end

endmodule

// File: tb/tb_switch_led_ctrl.sv
// Self-checking bench for switch_led_ctrl: directed scenarios plus random
// stimulus against a history-based reference model.
module tb_switch_led_ctrl;

    localparam int NUM_CH = 4;
    localparam int DC     = 4;
    localparam int BD     = 3;
`ifdef SWITCH_LED_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [NUM_CH-1:0] sw    = '0;
    logic [2*NUM_CH-1:0] mode = '0;
    logic [NUM_CH-1:0] led;
    logic [NUM_CH-1:0] press;

    int errors = 0;
    int checks = 0;

    switch_led_ctrl #(
        .NUM_CH         (NUM_CH),
        .DEBOUNCE_CYCLES(DC),
        .BLINK_DIV      (BD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .switch     (sw),
        .mode       (mode),
        .led        (led),
        .press_pulse(press)
    );

    always #5 clk = ~clk;

    // Reference model: db takes a level once the last DC synchronised samples all
    // agree on it; blink phase is (edges since reset / BD) mod 2.
    logic [NUM_CH-1:0] m_sync1 = '0, m_sws = '0, m_db = '0, m_db_prev = '0;
    logic [NUM_CH-1:0] m_tog = '0, m_led = '0, m_press = '0;
    logic              m_hist [NUM_CH][DC];
    int                m_n = 0;

    task automatic model_step();
        logic [NUM_CH-1:0] n_db, n_tog, n_led, n_press;
        logic [1:0] md;
        logic same, rise, ph;
        if (!rst_n) begin
            m_sync1 = '0; m_sws = '0; m_db = '0; m_db_prev = '0;
            m_tog = '0; m_led = '0; m_press = '0; m_n = 0;
            for (int i = 0; i < NUM_CH; i++)
                for (int k = 0; k < DC; k++) m_hist[i][k] = 1'b0;
            return;
        end
        ph = ((m_n / BD) % 2) == 1;
        for (int i = 0; i < NUM_CH; i++) begin
            for (int k = DC - 1; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
            m_hist[i][0] = m_sws[i];
            same = 1'b1;
            for (int k = 1; k < DC; k++) if (m_hist[i][k] != m_hist[i][0]) same = 1'b0;
            n_db[i]    = (same && m_hist[i][0] != m_db[i]) ? m_hist[i][0] : m_db[i];
            rise       = m_db[i] && !m_db_prev[i];
            n_press[i] = rise;
            md         = mode[2*i +: 2];
            n_tog[i]   = m_tog[i] ^ (rise && md == 2'b01);
            case (md)
                2'b00:   n_led[i] = m_db[i];
                2'b01:   n_led[i] = n_tog[i];
                2'b10:   n_led[i] = BLINK_ON ? (m_db[i] & ph) : m_db[i];
                default: n_led[i] = 1'b0;
            endcase
        end
        m_db_prev = m_db;
        m_db      = n_db;
        m_tog     = n_tog;
        m_led     = n_led;
        m_press   = n_press;
        m_sws     = m_sync1;
        m_sync1   = sw;
        m_n++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic press_ch(input int ch);
        sw[ch] = 1'b1;
        repeat (10) tick();
        sw[ch] = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_reset();
        sw    = '1;
        mode  = 8'b11_10_01_00;
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (led !== '0) begin errors++; $display("FAIL reset_led got=%b want=0000", led); end
        checks++;
        if (press !== '0) begin errors++; $display("FAIL reset_press got=%b want=0000", press); end
        sw    = '0;
        mode  = '0;
        rst_n = 1'b1;
        repeat (10) tick();
        checks++;
        if (led !== '0 || press !== '0)
        begin errors++; $display("FAIL reset_idle led=%b press=%b want=0000/0000", led, press); end
    endtask

    task automatic test_follow();
        logic [NUM_CH-1:0] el, ep;
        sw[0] = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            el = (t >= 7) ? 4'b0001 : 4'b0000;
            ep = (t == 7) ? 4'b0001 : 4'b0000;
            checks++;
            if (led !== el || press !== ep) begin
                errors++;
                $display("FAIL follow t=%0d led=%b press=%b want led=%b press=%b", t, led, press, el, ep);
            end
        end
    endtask

    task automatic test_glitch();
        sw[1] = 1'b1;
        repeat (3) tick();
        sw[1] = 1'b0;
        for (int t = 0; t < 15; t++) begin
            tick();
            checks++;
            if (led[1] !== 1'b0 || press[1] !== 1'b0) begin
                errors++;
                $display("FAIL glitch t=%0d led1=%b press1=%b want 0/0", t, led[1], press[1]);
            end
        end
        sw[0] = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_toggle();
        logic exp_l;
        mode[5:4] = 2'b01;
        tick();
        checks++;
        if (led[2] !== 1'b0) begin errors++; $display("FAIL toggle_init got=%b want=0", led[2]); end
        exp_l = 1'b0;
        for (int p = 0; p < 3; p++) begin
            exp_l = ~exp_l;
            sw[2] = 1'b1;
            repeat (10) tick();
            checks++;
            if (led[2] !== exp_l) begin errors++; $display("FAIL toggle_press%0d got=%b want=%b", p, led[2], exp_l); end
            sw[2] = 1'b0;
            repeat (10) tick();
            checks++;
            if (led[2] !== exp_l) begin errors++; $display("FAIL toggle_release%0d got=%b want=%b", p, led[2], exp_l); end
        end
        mode[5:4] = 2'b00;
        press_ch(2);
        checks++;
        if (led[2] !== 1'b0) begin errors++; $display("FAIL toggle_follow got=%b want=0", led[2]); end
        mode[5:4] = 2'b01;
        tick();
        checks++;
        if (led[2] !== 1'b1) begin errors++; $display("FAIL toggle_held got=%b want=1", led[2]); end
        mode[5:4] = 2'b00;
        tick();
    endtask

    task automatic test_blink();
        logic s [12];
        mode[7:6] = 2'b10;
        sw[3]     = 1'b1;
        repeat (12) tick();
        for (int t = 0; t < 12; t++) begin
            tick();
            s[t] = led[3];
            checks++;
            if (led[3] !== m_led[3]) begin errors++; $display("FAIL blink_model t=%0d got=%b want=%b", t, led[3], m_led[3]); end
        end
        for (int t = 0; t < 9; t++) begin
            checks++;
            if (BLINK_ON ? (s[t] === s[t+3]) : (s[t] !== 1'b1)) begin
                errors++;
                $display("FAIL blink_pattern t=%0d got=%b later=%b", t, s[t], s[t+3]);
            end
        end
        sw[3]     = 1'b0;
        mode[7:6] = 2'b00;
        repeat (10) tick();
    endtask

    task automatic test_off();
        int pulses;
        pulses    = 0;
        mode[1:0] = 2'b11;
        sw[0]     = 1'b1;
        for (int t = 0; t < 14; t++) begin
            tick();
            if (press[0] === 1'b1) pulses++;
            checks++;
            if (led[0] !== 1'b0) begin errors++; $display("FAIL off_led t=%0d got=%b want=0", t, led[0]); end
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL off_pulses got=%0d want=1", pulses); end
        sw[0] = 1'b0;
        repeat (10) tick();
        mode[1:0] = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid();
        sw    = '0;
        mode  = '0;
        repeat (10) tick();
        sw[1] = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (led !== '0 || press !== '0)
        begin errors++; $display("FAIL rstmid_clear led=%b press=%b want 0000/0000", led, press); end
        rst_n = 1'b1;
        repeat (6) tick();
        checks++;
        if (led !== '0 || press !== '0)
        begin errors++; $display("FAIL rstmid_early led=%b press=%b want 0000/0000", led, press); end
        tick();
        checks++;
        if (led !== 4'b0010 || press !== 4'b0010)
        begin errors++; $display("FAIL rstmid_full led=%b press=%b want 0010/0010", led, press); end
        sw = '0;
        repeat (10) tick();
    endtask

    task automatic test_random();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ($urandom_range(9) == 0)  sw[i] = ~sw[i];
                if ($urandom_range(24) == 0) mode[2*i +: 2] = 2'($urandom_range(3));
            end
            rst_n = ($urandom_range(399) != 0);
            tick();
            checks++;
            if (led !== m_led || press !== m_press) begin
                errors++;
                $display("FAIL random c=%0d led=%b press=%b want led=%b press=%b", c, led, press, m_led, m_press);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_follow();
        test_glitch();
        test_toggle();
        test_blink();
        test_off();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
